// File: rtl/branch_pc_unit_if.sv
// Interface between the decode/compare stage and the PC/branch-resolution unit.
// The master drives the decoded control instruction and the comparator answer.
// The slave returns the fetch PC, the flush and branch-taken pulses, and the taken counter.
interface branch_pc_unit_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             instr_valid;
    logic [31:0]      instr_pc;
    logic             is_beq;
    logic             is_bne;
    logic             is_jump;
    logic             equal;
    logic [15:0]      imm16;
    logic [25:0]      jtarget26;
    logic [31:0]      pc;
    logic             flush;
    logic             branch_taken;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output stall, instr_valid, instr_pc, is_beq, is_bne, is_jump,
               equal, imm16, jtarget26,
        input  pc, flush, branch_taken, taken_count
    );

    modport slave (
        input  stall, instr_valid, instr_pc, is_beq, is_bne, is_jump,
               equal, imm16, jtarget26,
        output pc, flush, branch_taken, taken_count
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution.
// Holds the architectural PC, chooses PC+4 / branch target / jump target,
// squashes wrong-path slots for FLUSH_CYCLES cycles after every taken transfer,
// and keeps a saturating count of taken transfers.
// FLUSH_CYCLES must lie in 1..3; the flush counter is two bits wide.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [31:0]        pc_cur;
    logic [31:0]        pc_next;
    logic [1:0]         fcnt;
    logic [1:0]         fcnt_next;
    logic               taken_cur;
    logic               taken_next;
    logic [CNT_W-1:0]   count_cur;
    logic [CNT_W-1:0]   count_next;

    logic [31:0]        pc_plus4;
    logic [31:0]        instr_pc_plus4;
    logic [31:0]        branch_off;
    logic [31:0]        branch_target;
    logic [31:0]        jump_target;
    logic               take;
    logic [31:0]        take_target;

    assign pc_plus4       = pc_cur + 32'd4;
    assign instr_pc_plus4 = bus.instr_pc + 32'd4;
    assign branch_off     = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign branch_target  = instr_pc_plus4 + branch_off;
    assign jump_target    = {instr_pc_plus4[31:28], bus.jtarget26, 2'b00};

    // Taken decision with jump > beq > bne priority; target wraps modulo 2^32.
    always_comb begin
        take        = 1'b0;
        take_target = pc_plus4;
        if (bus.is_jump) begin
            take        = 1'b1;
            take_target = jump_target;
        end else if (bus.is_beq && bus.equal) begin
            take        = 1'b1;
            take_target = branch_target;
        end else if (bus.is_bne && !bus.equal) begin
            take        = 1'b1;
            take_target = branch_target;
        end
    end

    // Next-state and next-register values; a stalled cycle leaves everything as is.
    always_comb begin
        state_next = state;
        pc_next    = pc_cur;
        fcnt_next  = fcnt;
        taken_next = taken_cur;
        count_next = count_cur;
        if (!bus.stall) begin
            taken_next = 1'b0;
            case (state)
                BOOT: begin
                    state_next = RUN;
                end
                RUN: begin
                    pc_next = pc_plus4;
                    if (bus.instr_valid && take) begin
                        pc_next    = take_target;
                        taken_next = 1'b1;
                        state_next = FLUSH;
                        fcnt_next  = 2'd0;
                        if (count_cur != {CNT_W{1'b1}}) begin
                            count_next = count_cur + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Wrong-path slots keep advancing sequentially behind the target.
                    pc_next = pc_plus4;
                    if (fcnt == FLUSH_LAST) begin
                        fcnt_next  = 2'd0;
                        state_next = RUN;
                    end else begin
                        fcnt_next = fcnt + 2'd1;
                    end
                end
                default: begin
                    state_next = BOOT;
                    fcnt_next  = 2'd0;
                end
            endcase
        end
    end

    // State register; async reset drops flush immediately because flush decodes state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc_cur    <= RESET_PC;
            fcnt      <= 2'd0;
            taken_cur <= 1'b0;
            count_cur <= '0;
        end else begin
            state     <= state_next;
            pc_cur    <= pc_next;
            fcnt      <= fcnt_next;
            taken_cur <= taken_next;
            count_cur <= count_next;
        end
    end

    assign bus.pc           = pc_cur;
    assign bus.flush        = (state == FLUSH);
    assign bus.branch_taken = taken_cur;
    assign bus.taken_count  = count_cur;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a vector table on a default instance, plus
// hand-written sequences on a FLUSH_CYCLES=2 / CNT_W=4 / RESET_PC=0x1000 instance.
module tb_branch_pc_unit;
    logic clk = 1'b0;
    logic rst_n0 = 1'b0;
    logic rst_n1 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_pc_unit_if #(.CNT_W(16)) bi0 ();
    branch_pc_unit_if #(.CNT_W(4))  bi1 ();

    branch_pc_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(bi0)
    );
    branch_pc_unit #(.RESET_PC(32'h0000_1000), .FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(bi1)
    );

    typedef struct {
        logic        stall, valid, beq, bne, jmp, eq;
        logic [31:0] ipc;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] e_pc;
        logic        e_flush, e_bt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic s, logic v, logic b, logic n, logic j, logic e,
                                logic [31:0] ipc, logic [15:0] imm, logic [25:0] jt,
                                logic [31:0] e_pc, logic e_flush, logic e_bt,
                                logic [15:0] e_cnt);
        vec_t r;
        r.stall = s; r.valid = v; r.beq = b; r.bne = n; r.jmp = j; r.eq = e;
        r.ipc = ipc; r.imm = imm; r.jt = jt;
        r.e_pc = e_pc; r.e_flush = e_flush; r.e_bt = e_bt; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input vec_t v);
        bi0.stall = v.stall; bi0.instr_valid = v.valid; bi0.instr_pc = v.ipc;
        bi0.is_beq = v.beq; bi0.is_bne = v.bne; bi0.is_jump = v.jmp;
        bi0.equal = v.eq; bi0.imm16 = v.imm; bi0.jtarget26 = v.jt;
    endtask

    task automatic drive1(input logic v, input logic b, input logic j, input logic e,
                          input logic [31:0] ipc, input logic [15:0] imm, input logic [25:0] jt);
        bi1.stall = 1'b0; bi1.instr_valid = v; bi1.instr_pc = ipc;
        bi1.is_beq = b; bi1.is_bne = 1'b0; bi1.is_jump = j;
        bi1.equal = e; bi1.imm16 = imm; bi1.jtarget26 = jt;
    endtask

    task automatic chk1(input string tag, input logic [31:0] pc, input logic fl,
                        input logic bt, input logic [3:0] cnt);
        chk({tag, ".pc"}, bi1.pc, pc);
        chk({tag, ".flush"}, {31'b0, bi1.flush}, {31'b0, fl});
        chk({tag, ".bt"}, {31'b0, bi1.branch_taken}, {31'b0, bt});
        chk({tag, ".cnt"}, {28'b0, bi1.taken_count}, {28'b0, cnt});
    endtask

    initial begin
        vec_t idle;
        int   exp_cnt;
        idle = mk(0,0,0,0,0,0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 16'd0);

        //          s v b n j e  instr_pc       imm       jt            exp_pc        fl bt cnt
        tbl[0]  = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h0,        0, 0, 16'd0);
        tbl[1]  = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h4,        0, 0, 16'd0);
        tbl[2]  = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h8,        0, 0, 16'd0);
        tbl[3]  = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'hC,        0, 0, 16'd0);
        tbl[4]  = mk(0,1,1,0,0,1, 32'h8,        16'h0003, 26'h0,        32'h18,       1, 1, 16'd1);
        tbl[5]  = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h1C,       0, 0, 16'd1);
        tbl[6]  = mk(0,1,0,1,0,1, 32'h8,        16'h0003, 26'h0,        32'h20,       0, 0, 16'd1);
        tbl[7]  = mk(0,1,0,1,0,0, 32'h40,       16'hFFFE, 26'h0,        32'h3C,       1, 1, 16'd2);
        tbl[8]  = mk(0,1,1,0,0,1, 32'h100,      16'h0005, 26'h0,        32'h40,       0, 0, 16'd2);
        tbl[9]  = mk(0,1,1,0,1,1, 32'hF000_0000,16'h0003, 26'h40,       32'hF000_0100,1, 1, 16'd3);
        tbl[10] = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'hF000_0104,0, 0, 16'd3);
        tbl[11] = mk(0,1,1,0,0,0, 32'h10,       16'h0003, 26'h0,        32'hF000_0108,0, 0, 16'd3);
        tbl[12] = mk(1,1,1,0,0,1, 32'h10,       16'h0003, 26'h0,        32'hF000_0108,0, 0, 16'd3);
        tbl[13] = mk(0,1,0,0,1,0, 32'hFFFF_FFFC,16'h0,    26'h3FF_FFFF, 32'h0FFF_FFFC,1, 1, 16'd4);
        tbl[14] = mk(1,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h0FFF_FFFC,1, 1, 16'd4);
        tbl[15] = mk(1,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h0FFF_FFFC,1, 1, 16'd4);
        tbl[16] = mk(1,1,0,0,1,0, 32'h0,        16'h0,    26'h7,        32'h0FFF_FFFC,1, 1, 16'd4);
        tbl[17] = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h1000_0000,0, 0, 16'd4);
        tbl[18] = mk(0,1,1,0,0,1, 32'hFFFF_FFF8,16'h0002, 26'h0,        32'h4,        1, 1, 16'd5);
        tbl[19] = mk(0,0,0,0,0,0, 32'h0,        16'h0,    26'h0,        32'h8,        0, 0, 16'd5);
        tbl[20] = mk(0,0,0,0,1,0, 32'h0,        16'h0,    26'h5,        32'hC,        0, 0, 16'd5);

        drive0(idle);
        drive1(0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        tick();
        tick();
        chk("rst0.pc", bi0.pc, 32'h0);
        chk("rst0.flush", {31'b0, bi0.flush}, 32'h0);
        chk("rst0.bt", {31'b0, bi0.branch_taken}, 32'h0);
        chk("rst0.cnt", {16'b0, bi0.taken_count}, 32'h0);
        rst_n0 = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive0(tbl[i]);
            tick();
            chk($sformatf("v%0d.pc", i), bi0.pc, tbl[i].e_pc);
            chk($sformatf("v%0d.flush", i), {31'b0, bi0.flush}, {31'b0, tbl[i].e_flush});
            chk($sformatf("v%0d.bt", i), {31'b0, bi0.branch_taken}, {31'b0, tbl[i].e_bt});
            chk($sformatf("v%0d.cnt", i), {16'b0, bi0.taken_count}, {16'b0, tbl[i].e_cnt});
        end
        drive0(idle);

        // Second instance: reset value, BOOT hold, two-cycle flush ignoring instr_valid.
        chk1("r1", 32'h1000, 0, 0, 4'd0);
        rst_n1 = 1'b1;
        tick();
        chk1("boot1", 32'h1000, 0, 0, 4'd0);
        drive1(1, 1, 0, 1, 32'h0, 16'h0010, 26'h0);
        tick();
        chk1("b1", 32'h44, 1, 1, 4'd1);
        drive1(1, 0, 1, 0, 32'h0, 16'h0, 26'h123);
        tick();
        chk1("f1a", 32'h48, 1, 0, 4'd1);
        drive1(0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        tick();
        chk1("f1b", 32'h4C, 0, 0, 4'd1);

        // Drive the 4-bit counter past saturation with 16 more jumps to address 0.
        for (int i = 2; i <= 17; i++) begin
            exp_cnt = (i < 15) ? i : 15;
            drive1(1, 0, 1, 0, 32'h0, 16'h0, 26'h0);
            tick();
            chk1($sformatf("j%0d", i), 32'h0, 1, 1, 4'(exp_cnt));
            drive1(0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
            tick();
            tick();
        end
        chk("sat.pc", bi1.pc, 32'h8);

        // Asynchronous reset in the middle of a flush.
        drive1(1, 0, 1, 0, 32'h0, 16'h0, 26'h10);
        tick();
        chk1("pre_rst", 32'h40, 1, 1, 4'hF);
        rst_n1 = 1'b0;
        #1;
        chk1("mid_rst", 32'h1000, 0, 0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
